rx_operand_sequencer: RTL and testbench
=======================================

# rx_operand_sequencer

Command sequencer between the UART RX interface and the operand input memory / datapath. It parses a 5-byte command packet (opcode, A MSB, A LSB, B MSB, B LSB) from the RX byte stream and drives the input memory's four load enables in step with the incoming bytes. It then starts the datapath, waits for completion, and returns the 16-bit result MSB-first over a valid/ready TX byte interface. It also rejects invalid opcodes and aborts stalled packets on an inter-byte timeout.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100000: number of idle cycles allowed between packet bytes before the packet is aborted (≥2).
- NUM_OPS, 8: opcodes 0..NUM_OPS-1 are valid (NUM_OPS ≤ 256).

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- Rx_Valid_in  in  1  one-cycle strobe; Rx_Byte_in is valid this cycle.
- Rx_Byte_in  in  8  received byte.
- Load_MSB_a_en_out  out  1  load enable to input memory, A[15:8].
- Load_LSB_a_en_out  out  1  load enable to input memory, A[7:0].
- Load_MSB_b_en_out  out  1  load enable to input memory, B[15:8].
- Load_LSB_b_en_out  out  1  load enable to input memory, B[7:0].
- Opcode_out  out  8  registered opcode of the current packet.
- Start_out  out  1  one-cycle datapath start pulse.
- Done_in  in  1  datapath completion strobe.
- Result_in  in  16  datapath result; valid when Done_in=1.
- Tx_Data_out  out  8  byte to UART TX.
- Tx_Valid_out  out  1  Tx_Data_out valid.
- Tx_Ready_in  in  1  TX accepts the byte.
- Busy_out  out  1  high whenever state ≠ IDLE.
- Err_out  out  1  one-cycle error pulse (invalid opcode or timeout).

## Operation
- States: IDLE → A_MSB → A_LSB → B_MSB → B_LSB → START → WAIT_DONE → TX_MSB → TX_LSB → IDLE.
- IDLE: on Rx_Valid_in, if Rx_Byte_in < NUM_OPS, register it into Opcode_out and go to A_MSB. Otherwise drop the byte, pulse Err_out, and stay in IDLE.
- A_MSB/A_LSB/B_MSB/B_LSB: each Rx_Valid_in accepts one byte and advances one state.
- Load enables are combinational: Load_X_en_out = Rx_Valid_in AND (state == X). They are asserted in the same cycle as the byte, and the input memory captures it at that edge. Exactly one enable is high at a time. All enables are 0 outside these four states.
- START: Start_out = 1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: Done_in is sampled only in this state. On Done_in, latch Result_in into the internal result register and go to TX_MSB. There is no timeout in this state.
- TX_MSB: Tx_Valid_out = 1, Tx_Data_out = result[15:8]. Advance on Tx_Valid_out AND Tx_Ready_in at an edge.
- TX_LSB: same as TX_MSB with result[7:0]. On handshake go to IDLE.
- Rx_Valid_in is ignored (no loads, no error) in START, WAIT_DONE, TX_MSB and TX_LSB. Done_in is ignored outside WAIT_DONE.
- Timeout counter:
  - Width $clog2(TIMEOUT_CYCLES).
  - Cleared on entry to A_MSB and on every accepted byte.
  - Increments each cycle spent in A_MSB..B_LSB without Rx_Valid_in.
  - When the counter == TIMEOUT_CYCLES-1 and Rx_Valid_in = 0: go to IDLE and pulse Err_out.
  - If a byte arrives in that same cycle, the byte wins: it is accepted and no error is raised.
- An aborted packet leaves any operand bytes already loaded in the input memory; this block never clears them.

## Timing
- Reset values: state IDLE; Opcode_out 0x00; Tx_Data_out 0x00; result register 0x0000; timeout counter 0. Outputs Tx_Valid_out, Start_out, Busy_out, Err_out and all Load_*_en_out are 0.
- Reset mid-operation: IDLE at the next edge; the partial packet and any pending TX byte are discarded.
- Opcode accepted at edge t → Opcode_out valid from t+1.
- B LSB accepted at edge t → START (Start_out = 1) during cycle t+1. The input memory presents the full B operand from t+1. WAIT_DONE begins at t+2.
- Done_in at edge d → Tx_Valid_out = 1 with the MSB from d+1.
- Tx_Data_out and Tx_Valid_out stay stable while Tx_Ready_in = 0. The LSB is presented the cycle after the MSB handshake.
- With Tx_Ready_in tied high, the result occupies 2 cycles. Busy_out falls the cycle after the LSB handshake.
- Err_out is registered: it is high in the cycle after the offending byte or the timeout cycle.

## Test plan
- Packet 0x02,0x12,0x34,0xAB,0xCD (bytes spaced 3 cycles), Done_in 4 cycles after Start_out with Result_in = 0xBEEF, Tx_Ready_in = 1:
  - Load pulses MSB_a, LSB_a, MSB_b, LSB_b, each coincident with its byte.
  - Opcode_out = 0x02; input memory A = 0x1234, B = 0xABCD.
  - One Start_out pulse; TX sends 0xBE then 0xEF; Busy_out returns to 0.
- Same packet, Tx_Ready_in held low 5 cycles in TX_MSB → Tx_Data_out holds 0xBE with Tx_Valid_out = 1 for those 5 cycles; 0xEF follows the handshake.
- NUM_OPS = 8: byte 0x09 in IDLE → Err_out pulse, no load enables, stays IDLE. Next byte 0x01 is accepted as the opcode.
- TIMEOUT_CYCLES = 16: send 0x01,0x00,0x05, then silence → abort after 16 idle cycles: Err_out pulse, IDLE, Busy_out = 0. Repeat with the next byte arriving on idle cycle 16 → byte accepted (Load_MSB_b_en_out = 1), no Err_out.
- Rx bytes 0x55 injected during START, WAIT_DONE and TX_MSB → no load enables and no Err_out; Opcode_out is unchanged.
- RST asserted during WAIT_DONE, then Done_in = 1 → all outputs at reset values the cycle after RST; Done_in ignored, no TX activity.

Source files
------------

// File: rtl/rx_operand_sequencer.sv
// Command sequencer: parses opcode + two 16-bit operands from the RX byte stream,
// strobes the operand memory loads, runs the datapath and returns the result MSB-first.
module rx_operand_sequencer #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int NUM_OPS        = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Rx_Valid_in,
    input  logic [7:0]  Rx_Byte_in,
    output logic        Load_MSB_a_en_out,
    output logic        Load_LSB_a_en_out,
    output logic        Load_MSB_b_en_out,
    output logic        Load_LSB_b_en_out,
    output logic [7:0]  Opcode_out,
    output logic        Start_out,
    input  logic        Done_in,
    input  logic [15:0] Result_in,
    output logic [7:0]  Tx_Data_out,
    output logic        Tx_Valid_out,
    input  logic        Tx_Ready_in,
    output logic        Busy_out,
    output logic        Err_out
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        IDLE, A_MSB, A_LSB, B_MSB, B_LSB, START, WAIT_DONE, TX_MSB, TX_LSB
    } state_t;

    state_t        state;
    logic [15:0]   result;
    logic [CW-1:0] idle_cnt;
    logic          op_ok;
    logic          timeout_hit;
    logic          tx_fire;

    // 9-bit compare so NUM_OPS = 256 accepts every opcode
    assign op_ok       = ({1'b0, Rx_Byte_in} < 9'(NUM_OPS));
    assign timeout_hit = !Rx_Valid_in && (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign tx_fire     = Tx_Valid_out && Tx_Ready_in;

    // Load enables are combinational so the memory captures the byte on the same edge
    assign Load_MSB_a_en_out = Rx_Valid_in && (state == A_MSB);
    assign Load_LSB_a_en_out = Rx_Valid_in && (state == A_LSB);
    assign Load_MSB_b_en_out = Rx_Valid_in && (state == B_MSB);
    assign Load_LSB_b_en_out = Rx_Valid_in && (state == B_LSB);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            result       <= '0;
            idle_cnt     <= '0;
            Opcode_out   <= '0;
            Tx_Data_out  <= '0;
            Tx_Valid_out <= 1'b0;
            Start_out    <= 1'b0;
            Busy_out     <= 1'b0;
            Err_out      <= 1'b0;
        end else begin
            Err_out   <= 1'b0;
            Start_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (Rx_Valid_in) begin
                        if (op_ok) begin
                            Opcode_out <= Rx_Byte_in;
                            idle_cnt   <= '0;
                            Busy_out   <= 1'b1;
                            state      <= A_MSB;
                        end else begin
                            Err_out <= 1'b1;
                        end
                    end
                end
                A_MSB, A_LSB, B_MSB, B_LSB: begin
                    if (Rx_Valid_in) begin
                        idle_cnt <= '0;
                        case (state)
                            A_MSB:   state <= A_LSB;
                            A_LSB:   state <= B_MSB;
                            B_MSB:   state <= B_LSB;
                            default: begin
                                state     <= START;
                                Start_out <= 1'b1;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        // operand bytes already loaded are left in the memory
                        state    <= IDLE;
                        Busy_out <= 1'b0;
                        Err_out  <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                START: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (Done_in) begin
                        result       <= Result_in;
                        Tx_Data_out  <= Result_in[15:8];
                        Tx_Valid_out <= 1'b1;
                        state        <= TX_MSB;
                    end
                end
                TX_MSB: begin
                    if (tx_fire) begin
                        Tx_Data_out <= result[7:0];
                        state       <= TX_LSB;
                    end
                end
                TX_LSB: begin
                    if (tx_fire) begin
                        Tx_Valid_out <= 1'b0;
                        Busy_out     <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    Tx_Valid_out <= 1'b0;
                    Busy_out     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_operand_sequencer.sv
// Bench for rx_operand_sequencer: vector table for the packet bytes, TX scoreboard,
// and directed sequences for stall, timeout, ignored bytes and mid-operation reset.
module tb_rx_operand_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        Rx_Valid_in = 1'b0;
    logic [7:0]  Rx_Byte_in = '0;
    logic        Load_MSB_a_en_out, Load_LSB_a_en_out, Load_MSB_b_en_out, Load_LSB_b_en_out;
    logic [7:0]  Opcode_out;
    logic        Start_out;
    logic        Done_in = 1'b0;
    logic [15:0] Result_in = '0;
    logic [7:0]  Tx_Data_out;
    logic        Tx_Valid_out;
    logic        Tx_Ready_in = 1'b1;
    logic        Busy_out;
    logic        Err_out;

    rx_operand_sequencer #(.TIMEOUT_CYCLES(16), .NUM_OPS(8)) dut (
        .CLK(CLK), .RST(RST),
        .Rx_Valid_in(Rx_Valid_in), .Rx_Byte_in(Rx_Byte_in),
        .Load_MSB_a_en_out(Load_MSB_a_en_out), .Load_LSB_a_en_out(Load_LSB_a_en_out),
        .Load_MSB_b_en_out(Load_MSB_b_en_out), .Load_LSB_b_en_out(Load_LSB_b_en_out),
        .Opcode_out(Opcode_out), .Start_out(Start_out),
        .Done_in(Done_in), .Result_in(Result_in),
        .Tx_Data_out(Tx_Data_out), .Tx_Valid_out(Tx_Valid_out), .Tx_Ready_in(Tx_Ready_in),
        .Busy_out(Busy_out), .Err_out(Err_out)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] mem_a = '0, mem_b = '0;

    typedef struct {
        logic [7:0] b;
        logic [3:0] ld;     // {MSB_a, LSB_a, MSB_b, LSB_b}
        logic       err;
        logic       busy;
        logic       start;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Operand memory model driven by the load enables
    always @(posedge CLK) begin
        if (Load_MSB_a_en_out) mem_a[15:8] <= Rx_Byte_in;
        if (Load_LSB_a_en_out) mem_a[7:0]  <= Rx_Byte_in;
        if (Load_MSB_b_en_out) mem_b[15:8] <= Rx_Byte_in;
        if (Load_LSB_b_en_out) mem_b[7:0]  <= Rx_Byte_in;
    end

    // TX scoreboard: each handshake pops one expected byte
    always @(negedge CLK) begin
        if (Start_out) start_cnt++;
        if (!RST && Tx_Valid_out && Tx_Ready_in) begin
            if (exp_q.size() == 0) begin
                check("tx_unexpected", {24'h0, Tx_Data_out}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", {24'h0, Tx_Data_out}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [3:0] ld);
        Rx_Valid_in = 1'b1;
        Rx_Byte_in  = b;
        #1;
        ld = {Load_MSB_a_en_out, Load_LSB_a_en_out, Load_MSB_b_en_out, Load_LSB_b_en_out};
        tick();
        Rx_Valid_in = 1'b0;
        Rx_Byte_in  = '0;
    endtask

    task automatic send_packet(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [3:0] ld;
        logic [7:0] bytes[5];
        bytes = '{op, a[15:8], a[7:0], b[15:8], b[7:0]};
        for (int i = 0; i < 5; i++) begin
            send_byte(bytes[i], ld);
            if (i < 4) repeat (2) tick();
        end
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        logic [3:0] ld;
        vecs[0] = '{8'h09, 4'b0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h02, 4'b0000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h12, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h34, 4'b0100, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'hAB, 4'b0010, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'hCD, 4'b0001, 1'b0, 1'b1, 1'b1};

        repeat (3) tick();
        RST = 1'b0;
        check("rst_opcode", Opcode_out, 8'h00);
        check("rst_txdata", Tx_Data_out, 8'h00);
        check("rst_txvalid", Tx_Valid_out, 1'b0);
        check("rst_start", Start_out, 1'b0);
        check("rst_busy", Busy_out, 1'b0);
        check("rst_err", Err_out, 1'b0);

        // Invalid opcode then a full packet, bytes 3 cycles apart
        start_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(vecs[i].b, ld);
            check($sformatf("vec%0d_load", i), ld, vecs[i].ld);
            check($sformatf("vec%0d_err", i), Err_out, vecs[i].err);
            check($sformatf("vec%0d_busy", i), Busy_out, vecs[i].busy);
            check($sformatf("vec%0d_start", i), Start_out, vecs[i].start);
            if (i < 5) repeat (2) tick();
        end
        check("opcode", Opcode_out, 8'h02);
        check("mem_a", mem_a, 16'h1234);
        check("mem_b", mem_b, 16'hABCD);
        tick();
        check("start_single", Start_out, 1'b0);
        repeat (3) tick();
        Done_in = 1'b1; Result_in = 16'hBEEF;
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        tick();
        Done_in = 1'b0; Result_in = '0;
        check("tx_valid", Tx_Valid_out, 1'b1);
        drain("drain1");
        check("busy_end1", Busy_out, 1'b0);
        check("start_count", start_cnt, 1);

        // TX backpressure: MSB held for 5 cycles
        send_packet(8'h02, 16'h1234, 16'hABCD);
        repeat (4) tick();
        Tx_Ready_in = 1'b0;
        Done_in = 1'b1; Result_in = 16'hBEEF;
        exp_q.push_back(8'hBE); exp_q.push_back(8'hEF);
        tick();
        Done_in = 1'b0; Result_in = '0;
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", Tx_Valid_out, 1'b1);
            check("stall_data", Tx_Data_out, 8'hBE);
            tick();
        end
        Tx_Ready_in = 1'b1;
        drain("drain2");
        check("busy_end2", Busy_out, 1'b0);

        // Timeout abort after 16 idle cycles
        send_byte(8'h01, ld); send_byte(8'h00, ld); send_byte(8'h05, ld);
        repeat (15) tick();
        check("to_busy_before", Busy_out, 1'b1);
        check("to_err_before", Err_out, 1'b0);
        tick();
        check("to_err", Err_out, 1'b1);
        check("to_busy", Busy_out, 1'b0);
        tick();
        check("to_err_clear", Err_out, 1'b0);

        // Byte on idle cycle 16 wins over the timeout
        send_byte(8'h01, ld); send_byte(8'h00, ld); send_byte(8'h05, ld);
        repeat (15) tick();
        send_byte(8'hAB, ld);
        check("late_load", ld, 4'b0010);
        check("late_err", Err_out, 1'b0);
        check("late_busy", Busy_out, 1'b1);
        send_byte(8'hCD, ld);
        check("late_start", Start_out, 1'b1);

        // Bytes in START, WAIT_DONE and TX_MSB are ignored
        send_byte(8'h55, ld);
        check("ign_start_load", ld, 4'b0000);
        check("ign_start_err", Err_out, 1'b0);
        send_byte(8'h55, ld);
        check("ign_wait_load", ld, 4'b0000);
        check("ign_wait_err", Err_out, 1'b0);
        Tx_Ready_in = 1'b0;
        Done_in = 1'b1; Result_in = 16'h1357;
        exp_q.push_back(8'h13); exp_q.push_back(8'h57);
        tick();
        Done_in = 1'b0; Result_in = '0;
        send_byte(8'h55, ld);
        check("ign_tx_load", ld, 4'b0000);
        check("ign_tx_err", Err_out, 1'b0);
        check("ign_tx_valid", Tx_Valid_out, 1'b1);
        check("ign_opcode", Opcode_out, 8'h01);
        check("ign_mem_a", mem_a, 16'h0005);
        check("ign_mem_b", mem_b, 16'hABCD);
        Tx_Ready_in = 1'b1;
        drain("drain3");

        // Reset during WAIT_DONE discards the packet; later Done_in is ignored
        send_packet(8'h03, 16'h1122, 16'h3344);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        Done_in = 1'b1; Result_in = 16'hFFFF;
        check("mrst_opcode", Opcode_out, 8'h00);
        check("mrst_busy", Busy_out, 1'b0);
        check("mrst_txvalid", Tx_Valid_out, 1'b0);
        tick();
        Done_in = 1'b0; Result_in = '0;
        for (int i = 0; i < 4; i++) begin
            check("mrst_no_tx", Tx_Valid_out, 1'b0);
            check("mrst_txdata", Tx_Data_out, 8'h00);
            check("mrst_idle", {Busy_out, Err_out, Start_out}, 3'b000);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
